// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle: hazard sources in, stall/flush/trap controls out.
interface hazard_ctrl_if;
    logic       br_taken;
    logic       is_mret;
    logic       intr_req;
    logic       mie;
    logic       dmem_req;
    logic       dmem_ack;
    logic       stall_if;
    logic       stall_de;
    logic       flush_de;
    logic       flush_mw;
    logic       trap_take;
    logic       bus_err;
    logic [1:0] state_o;

    modport master (
        output br_taken, is_mret, intr_req, mie, dmem_req, dmem_ack,
        input  stall_if, stall_de, flush_de, flush_mw, trap_take, bus_err, state_o
    );

    modport slave (
        input  br_taken, is_mret, intr_req, mie, dmem_req, dmem_ack,
        output stall_if, stall_de, flush_de, flush_mw, trap_take, bus_err, state_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/trap sequencer for a two-stage-after-fetch pipeline (IF, DE, MW).
// Optional data-memory timeout: define HAZARD_CTRL_DMEM_TIMEOUT_EN.
module hazard_ctrl (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        TRAP_DRAIN = 2'd2,
        TRAP_ENTER = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   holdoff;
    logic   mem_stall;
    logic   timeout;
    logic   stall_if_c, stall_de_c, flush_de_c, flush_mw_c, trap_take_c, bus_err_c;

    assign mem_stall = hz.dmem_req & ~hz.dmem_ack;

`ifdef HAZARD_CTRL_DMEM_TIMEOUT_EN
    // wait_cnt holds the number of earlier unacknowledged MEM_WAIT cycles,
    // so the 15th such cycle is the one that sees 14 and gives up.
    logic [3:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (state == MEM_WAIT && !hz.dmem_ack)
            wait_cnt <= wait_cnt + 4'd1;
        else
            wait_cnt <= '0;
    end

    assign timeout = (state == MEM_WAIT) && !hz.dmem_ack && (wait_cnt == 4'd14);
`else
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            holdoff <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == TRAP_ENTER)
                holdoff <= 1'b1;
            else if (state == RUN)
                holdoff <= 1'b0;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        stall_if_c  = 1'b0;
        stall_de_c  = 1'b0;
        flush_de_c  = 1'b0;
        flush_mw_c  = 1'b0;
        trap_take_c = 1'b0;
        bus_err_c   = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    stall_if_c = 1'b1;
                    stall_de_c = 1'b1;
                    state_nxt  = MEM_WAIT;
                end else if (hz.br_taken || hz.is_mret) begin
                    flush_de_c = 1'b1;
                end else if (hz.intr_req && hz.mie && !holdoff) begin
                    stall_if_c = 1'b1;
                    state_nxt  = TRAP_DRAIN;
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ack) begin
                    state_nxt = RUN;
                end else if (timeout) begin
                    bus_err_c  = 1'b1;
                    flush_mw_c = 1'b1;
                    state_nxt  = RUN;
                end else begin
                    stall_if_c = 1'b1;
                    stall_de_c = 1'b1;
                end
            end
            TRAP_DRAIN: begin
                // The request is latched by being here; a dropped intr_req no longer matters.
                stall_if_c = 1'b1;
                if (mem_stall)
                    stall_de_c = 1'b1;
                else
                    state_nxt = TRAP_ENTER;
            end
            TRAP_ENTER: begin
                trap_take_c = 1'b1;
                flush_de_c  = 1'b1;
                flush_mw_c  = 1'b1;
                state_nxt   = RUN;
            end
        endcase
    end

    // Reset masks every output so an interrupted sequence cannot leak a pulse.
    assign hz.stall_if  = ~rst & stall_if_c;
    assign hz.stall_de  = ~rst & stall_de_c;
    assign hz.flush_de  = ~rst & flush_de_c;
    assign hz.flush_mw  = ~rst & flush_mw_c;
    assign hz.trap_take = ~rst & trap_take_c;
    assign hz.bus_err   = ~rst & bus_err_c;
    assign hz.state_o   = rst ? 2'd0 : state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_hazard_ctrl;
    typedef struct packed {
        logic       stall_if;
        logic       stall_de;
        logic       flush_de;
        logic       flush_mw;
        logic       trap_take;
        logic       bus_err;
        logic [1:0] state;
    } exp_t;

`ifdef HAZARD_CTRL_DMEM_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int TIMEOUT_CYCLES = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    hazard_ctrl_if hz ();

    hazard_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: what the pipeline is currently doing, not an encoded state.
    bit in_mem_wait  = 1'b0;
    int trap_step    = 0;     // 0 none, 1 draining DE into MW, 2 taking the trap
    bit just_trapped = 1'b0;  // first RUN cycle after a trap ignores interrupts
    int waited       = 0;     // unacknowledged wait cycles so far

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic predict(output exp_t e);
        bit mem_stall;
        e = '0;
        mem_stall = hz.dmem_req && !hz.dmem_ack;
        if (rst) begin
            in_mem_wait  = 1'b0;
            trap_step    = 0;
            just_trapped = 1'b0;
            waited       = 0;
        end else if (in_mem_wait) begin
            e.state = 2'd1;
            if (hz.dmem_ack) begin
                in_mem_wait = 1'b0;
            end else if (TIMEOUT_EN && waited + 1 == TIMEOUT_CYCLES) begin
                e.bus_err   = 1'b1;
                e.flush_mw  = 1'b1;
                in_mem_wait = 1'b0;
            end else begin
                e.stall_if = 1'b1;
                e.stall_de = 1'b1;
                waited++;
            end
        end else if (trap_step == 1) begin
            e.state    = 2'd2;
            e.stall_if = 1'b1;
            if (mem_stall) e.stall_de = 1'b1;
            else           trap_step  = 2;
        end else if (trap_step == 2) begin
            e.state      = 2'd3;
            e.trap_take  = 1'b1;
            e.flush_de   = 1'b1;
            e.flush_mw   = 1'b1;
            trap_step    = 0;
            just_trapped = 1'b1;
        end else begin
            bit blocked;
            e.state      = 2'd0;
            blocked      = just_trapped;
            just_trapped = 1'b0;
            if (mem_stall) begin
                e.stall_if  = 1'b1;
                e.stall_de  = 1'b1;
                in_mem_wait = 1'b1;
                waited      = 0;
            end else if (hz.br_taken || hz.is_mret) begin
                e.flush_de = 1'b1;
            end else if (hz.intr_req && hz.mie && !blocked) begin
                e.stall_if = 1'b1;
                trap_step  = 1;
            end
        end
    endtask

    task automatic drive(input bit r, input bit br, input bit mr, input bit ir,
                         input bit me, input bit rq, input bit ak);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        hz.br_taken = br;
        hz.is_mret  = mr;
        hz.intr_req = ir;
        hz.mie      = me;
        hz.dmem_req = rq;
        hz.dmem_ack = ak;
        predict(e);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1, 0, 0);
    endtask

    // Monitor: compares whatever the DUT shows mid-cycle against the oldest prediction.
    initial begin
        exp_t got;
        exp_t want;
        logic prev_trap = 1'b0;
        int   cyc = 0;
        forever begin
            @(negedge clk);
            got = {hz.stall_if, hz.stall_de, hz.flush_de, hz.flush_mw,
                   hz.trap_take, hz.bus_err, hz.state_o};
            if (sb.size() != 0) begin
                want = sb.pop_front();
                check($sformatf("cycle %0d outputs", cyc), got, want);
                check($sformatf("cycle %0d trap/bus_err overlap", cyc),
                      {7'd0, got.trap_take & got.bus_err}, 8'd0);
                check($sformatf("cycle %0d trap_take width", cyc),
                      {7'd0, prev_trap & got.trap_take}, 8'd0);
                prev_trap = got.trap_take;
                cyc++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        hz.br_taken = 1'b0;
        hz.is_mret  = 1'b0;
        hz.intr_req = 1'b0;
        hz.mie      = 1'b0;
        hz.dmem_req = 1'b0;
        hz.dmem_ack = 1'b0;

        // Reset held for a few cycles.
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Load with delayed acknowledge.
        drive(0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 1, 1);
        idle(2);

        // Single taken branch, then MRET.
        drive(0, 1, 0, 0, 1, 0, 0);
        idle(1);
        drive(0, 0, 1, 0, 1, 0, 0);
        idle(1);

        // Interrupt held high: one trap, holdoff cycle, then re-entry.
        for (int i = 0; i < 7; i++) drive(0, 0, 0, 1, 1, 0, 0);
        idle(3);

        // Interrupt with branch in the same cycle.
        drive(0, 1, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Interrupt dropped during drain, with a memory stall in the drain.
        drive(0, 0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 1, 1);
        idle(3);

        // Interrupt masked by mie.
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0, 0);

        // Reset while in MEM_WAIT, and while draining a trap.
        drive(0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        drive(1, 0, 0, 0, 1, 1, 0);
        idle(2);
        drive(0, 0, 0, 1, 1, 0, 0);
        drive(1, 0, 0, 1, 1, 0, 0);
        idle(2);

        // Acknowledge never arrives for a long stretch.
        for (int i = 0; i < 33; i++) drive(0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 1, 1);
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 1) == 0));
        end
        idle(3);

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: %0d predictions left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
